// File: rtl/falafel_mem_responder.sv
// Purpose: memory-side responder for the falafel LSU request/response interface;
//          serves loads, stores and compare-and-swap on a word-organised on-chip array.
// Latency: request accepted at edge N -> response valid in cycle N+1+LATENCY.
// Backpressure: one op in flight; req_rdy drops from acceptance until the response
//               handshake, and the response is held stable while mem_rsp_rdy_i is low.
//
// Ports:
//   clk_i, rst_i        single clock; synchronous active-high reset (also clears the array)
//   mem_req_*           request channel (valid/ready), op = load / store / CAS
//   mem_rsp_*           response channel (valid/ready); data = load word, 0 for store,
//                       CAS status (0 = swapped, 1 = lock already held)
//   dbg_addr_i/dbg_data_o  side-effect-free combinational backdoor read
module falafel_mem_responder #(
   parameter int                 DATA_W    = 64,
   parameter int                 DEPTH     = 256,
   parameter int                 LATENCY   = 2,
   parameter logic [DATA_W-1:0]  EMPTY_KEY = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_req_val_i,
   output logic              mem_req_rdy_o,
   input  logic              mem_req_is_write_i,
   input  logic              mem_req_is_cas_i,
   input  logic [DATA_W-1:0] mem_req_addr_i,
   input  logic [DATA_W-1:0] mem_req_data_i,
   output logic              mem_rsp_val_o,
   input  logic              mem_rsp_rdy_i,
   output logic [DATA_W-1:0] mem_rsp_data_o,
   input  logic [DATA_W-1:0] dbg_addr_i,
   output logic [DATA_W-1:0] dbg_data_o
);

   // Byte address -> word index: drop the byte-in-word bits, keep log2(DEPTH)
   // bits above them, so higher address bits simply wrap.
   localparam int         IDX_LO   = $clog2(DATA_W / 8);
   localparam int         IDX_W    = $clog2(DEPTH);
   localparam logic [3:0] LAT_CNT  = 4'(LATENCY);
   localparam bit         ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;

   logic accept;     // request handshake this cycle
   logic commit;     // this edge is the transition into RESP
   logic rsp_done;   // response handshake this cycle

   // Operation captured at acceptance
   logic              lat_is_write;
   logic              lat_is_cas;
   logic [IDX_W-1:0]  lat_idx;
   logic [DATA_W-1:0] lat_data;

   // Operands used on the commit edge
   logic              c_is_write;
   logic              c_is_cas;
   logic [IDX_W-1:0]  c_idx;
   logic [DATA_W-1:0] c_data;
   logic [DATA_W-1:0] cur_word;
   logic              cas_hit;
   logic              do_write;
   logic [DATA_W-1:0] commit_rsp;

   logic [DEPTH-1:0][DATA_W-1:0] mem;
   logic [DATA_W-1:0]            rsp_data;
   logic [IDX_W-1:0]             req_idx;
   logic [IDX_W-1:0]             dbg_idx;

   // Only the index slice of each address is meaningful.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_req_addr_i, dbg_addr_i};

   assign req_idx = mem_req_addr_i[IDX_LO +: IDX_W];
   assign dbg_idx = dbg_addr_i[IDX_LO +: IDX_W];

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      mem_req_rdy_o = 1'b0;
      mem_rsp_val_o = 1'b0;
      accept        = 1'b0;
      commit        = 1'b0;
      rsp_done      = 1'b0;
      case (state)
         S_IDLE: begin
            mem_req_rdy_o = 1'b1;
            if (mem_req_val_i) begin
               accept  = 1'b1;
               cnt_nxt = LAT_CNT;
               // With no wait cycles the acceptance edge is also the commit edge.
               if (ZERO_LAT) begin
                  state_nxt = S_RESP;
                  commit    = 1'b1;
               end else begin
                  state_nxt = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) begin
               state_nxt = S_RESP;
               commit    = 1'b1;
            end
         end
         S_RESP: begin
            mem_rsp_val_o = 1'b1;
            if (mem_rsp_rdy_i) begin
               rsp_done  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Request capture
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lat_is_write <= 1'b0;
         lat_is_cas   <= 1'b0;
         lat_idx      <= '0;
         lat_data     <= '0;
      end else if (accept) begin
         lat_is_write <= mem_req_is_write_i;
         lat_is_cas   <= mem_req_is_cas_i;
         lat_idx      <= req_idx;
         lat_data     <= mem_req_data_i;
      end
   end

   // ------------------------------------------------------------------
   // Commit datapath: a commit from IDLE only happens in the zero-latency
   // build, where the op has not been captured yet, so take it straight
   // from the request bus.
   // ------------------------------------------------------------------
   always_comb begin
      if (state == S_IDLE) begin
         c_is_write = mem_req_is_write_i;
         c_is_cas   = mem_req_is_cas_i;
         c_idx      = req_idx;
         c_data     = mem_req_data_i;
      end else begin
         c_is_write = lat_is_write;
         c_is_cas   = lat_is_cas;
         c_idx      = lat_idx;
         c_data     = lat_data;
      end
   end

   // Read, compare and write all resolve on the single commit edge, which
   // together with the single outstanding op makes CAS atomic.
   always_comb begin
      cur_word   = mem[c_idx];
      cas_hit    = (cur_word == EMPTY_KEY);
      do_write   = 1'b0;
      commit_rsp = '0;
      if (c_is_cas) begin
         do_write   = commit && cas_hit;
         commit_rsp = cas_hit ? '0 : {{(DATA_W-1){1'b0}}, 1'b1};
      end else if (c_is_write) begin
         do_write   = commit;
         commit_rsp = '0;
      end else begin
         commit_rsp = cur_word;
      end
   end

   // ------------------------------------------------------------------
   // Storage array
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem <= '0;
      end else if (do_write) begin
         mem[c_idx] <= c_data;
      end
   end

   // ------------------------------------------------------------------
   // Response data register: loaded on commit, cleared on handshake so the
   // bus reads zero whenever the response is not valid.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_data <= '0;
      end else if (commit) begin
         rsp_data <= commit_rsp;
      end else if (rsp_done) begin
         rsp_data <= '0;
      end
   end

   assign mem_rsp_data_o = rsp_data;
   assign dbg_data_o     = mem[dbg_idx];

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Bench for falafel_mem_responder: a LATENCY=2 instance for the main scenarios and
// a LATENCY=0 instance for back-to-back throughput, both checked against
// word-array reference models.
module tb_falafel_mem_responder;

   localparam int DW    = 64;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;
   localparam int ZDEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          req_val, req_rdy, req_is_write, req_is_cas;
   logic [DW-1:0] req_addr, req_data;
   logic          rsp_val, rsp_rdy;
   logic [DW-1:0] rsp_data, dbg_addr, dbg_data;

   logic          z_req_val, z_req_rdy, z_req_is_write, z_req_is_cas;
   logic [DW-1:0] z_req_addr, z_req_data;
   logic          z_rsp_val;
   logic [DW-1:0] z_rsp_data, z_dbg_addr, z_dbg_data;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] model  [DEPTH];
   logic [DW-1:0] zmodel [ZDEPTH];

   falafel_mem_responder #(.DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk_i(clk), .rst_i(rst),
      .mem_req_val_i(req_val), .mem_req_rdy_o(req_rdy),
      .mem_req_is_write_i(req_is_write), .mem_req_is_cas_i(req_is_cas),
      .mem_req_addr_i(req_addr), .mem_req_data_i(req_data),
      .mem_rsp_val_o(rsp_val), .mem_rsp_rdy_i(rsp_rdy), .mem_rsp_data_o(rsp_data),
      .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
   );

   falafel_mem_responder #(.DATA_W(DW), .DEPTH(ZDEPTH), .LATENCY(0)) zdut (
      .clk_i(clk), .rst_i(rst),
      .mem_req_val_i(z_req_val), .mem_req_rdy_o(z_req_rdy),
      .mem_req_is_write_i(z_req_is_write), .mem_req_is_cas_i(z_req_is_cas),
      .mem_req_addr_i(z_req_addr), .mem_req_data_i(z_req_data),
      .mem_rsp_val_o(z_rsp_val), .mem_rsp_rdy_i(1'b1), .mem_rsp_data_o(z_rsp_data),
      .dbg_addr_i(z_dbg_addr), .dbg_data_o(z_dbg_data)
   );

   // ---------------- reference model ----------------
   function automatic int widx(input logic [DW-1:0] a);
      return int'((a / 8) % DEPTH);
   endfunction

   function automatic int zwidx(input logic [DW-1:0] a);
      return int'((a / 8) % ZDEPTH);
   endfunction

   function automatic logic [DW-1:0] model_op(input bit w, input bit c,
                                              input logic [DW-1:0] a, input logic [DW-1:0] d);
      int i = widx(a);
      logic [DW-1:0] r = '0;
      if (c) begin
         if (model[i] == '0) model[i] = d; else r = 1;
      end else if (w) model[i] = d;
      else r = model[i];
      return r;
   endfunction

   function automatic logic [DW-1:0] zmodel_op(input bit w, input bit c,
                                               input logic [DW-1:0] a, input logic [DW-1:0] d);
      int i = zwidx(a);
      logic [DW-1:0] r = '0;
      if (c) begin
         if (zmodel[i] == '0) zmodel[i] = d; else r = 1;
      end else if (w) zmodel[i] = d;
      else r = zmodel[i];
      return r;
   endfunction

   task automatic clear_models();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < ZDEPTH; i++) zmodel[i] = '0;
   endtask

   // One complete transaction on the LATENCY=2 instance. During a hold, if
   // poke is set, an illegal store is presented while req_rdy is low and
   // withdrawn before the handshake; it must never be sampled.
   task automatic do_op(input bit w, input bit c, input logic [DW-1:0] a,
                        input logic [DW-1:0] d, input int hold, input bit poke,
                        input logic [DW-1:0] pa, output logic [DW-1:0] got);
      logic [DW-1:0] exp;
      logic [DW-1:0] held;
      exp = model_op(w, c, a, d);
      @(negedge clk);
      req_val = 1'b1; req_is_write = w; req_is_cas = c; req_addr = a; req_data = d;
      rsp_rdy = (hold == 0);
      total++;
      if (req_rdy !== 1'b1) begin bad++; $display("FAIL op_req_rdy: got %b want 1", req_rdy); end
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         total++;
         if (rsp_val !== 1'b0 || req_rdy !== 1'b0 || rsp_data !== '0) begin
            bad++;
            $display("FAIL op_busy k=%0d: val=%b rdy=%b data=%h want 0 0 0", k, rsp_val, req_rdy, rsp_data);
         end
         @(negedge clk);
      end
      total++;
      if (rsp_val !== 1'b1) begin bad++; $display("FAIL op_latency: val=%b want 1 at N+%0d", rsp_val, LAT+1); end
      total++;
      if (rsp_data !== exp) begin bad++; $display("FAIL op_data @%h: got %h want %h", a, rsp_data, exp); end
      got  = rsp_data;
      held = rsp_data;
      if (hold > 0) begin
         if (poke) begin
            req_val = 1'b1; req_is_write = 1'b1; req_is_cas = 1'b0;
            req_addr = pa; req_data = 64'hBAD0_BAD0_BAD0_BAD0;
         end
         for (int k = 0; k < hold; k++) begin
            total++;
            if (rsp_val !== 1'b1 || rsp_data !== held || req_rdy !== 1'b0) begin
               bad++;
               $display("FAIL op_hold k=%0d: val=%b data=%h rdy=%b want 1 %h 0", k, rsp_val, rsp_data, req_rdy, held);
            end
            @(negedge clk);
         end
         req_val = 1'b0;
         rsp_rdy = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_val !== 1'b0 || rsp_data !== '0 || req_rdy !== 1'b1) begin
         bad++;
         $display("FAIL op_done: val=%b data=%h rdy=%b want 0 0 1", rsp_val, rsp_data, req_rdy);
      end
      dbg_addr = a;
      #1;
      total++;
      if (dbg_data !== model[widx(a)]) begin
         bad++; $display("FAIL op_dbg @%h: got %h want %h", a, dbg_data, model[widx(a)]);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clear_models();
      total++;
      if (req_rdy !== 1'b1 || rsp_val !== 1'b0 || rsp_data !== '0) begin
         bad++; $display("FAIL reset_outputs: rdy=%b val=%b data=%h want 1 0 0", req_rdy, rsp_val, rsp_data);
      end
      total++;
      if (z_req_rdy !== 1'b1 || z_rsp_val !== 1'b0 || z_rsp_data !== '0) begin
         bad++; $display("FAIL reset_z_outputs: rdy=%b val=%b data=%h want 1 0 0", z_req_rdy, z_rsp_val, z_rsp_data);
      end
      for (int i = 0; i < 4; i++) begin
         dbg_addr = DW'($urandom);
         #1;
         total++;
         if (dbg_data !== '0) begin bad++; $display("FAIL reset_mem @%h: got %h want 0", dbg_addr, dbg_data); end
      end
      rst = 1'b0;
   endtask

   task automatic test_store_load();
      logic [DW-1:0] got;
      do_op(1, 0, 64'h40, 64'hDEAD_BEEF, 0, 0, '0, got);
      total++;
      if (got !== '0) begin bad++; $display("FAIL store_rsp: got %h want 0", got); end
      do_op(0, 0, 64'h40, 64'h0, 0, 0, '0, got);
      total++;
      if (got !== 64'hDEAD_BEEF) begin bad++; $display("FAIL load_rsp: got %h want deadbeef", got); end
   endtask

   task automatic test_cas();
      logic [DW-1:0] got;
      do_op(0, 1, 64'h80, 64'h5, 0, 0, '0, got);
      total++;
      if (got !== '0) begin bad++; $display("FAIL cas_success: got %h want 0", got); end
      dbg_addr = 64'h80; #1;
      total++;
      if (dbg_data !== 64'h5) begin bad++; $display("FAIL cas_word: got %h want 5", dbg_data); end
      do_op(1, 1, 64'h80, 64'h7, 1, 0, '0, got);
      total++;
      if (got !== 64'h1) begin bad++; $display("FAIL cas_fail: got %h want 1", got); end
      dbg_addr = 64'h80; #1;
      total++;
      if (dbg_data !== 64'h5) begin bad++; $display("FAIL cas_kept: got %h want 5", dbg_data); end
   endtask

   task automatic test_hold();
      logic [DW-1:0] got;
      do_op(1, 0, 64'h200, 64'h1234_5678_9ABC_DEF0, 0, 0, '0, got);
      do_op(0, 0, 64'h200, 64'h0, 10, 1, 64'h300, got);
      total++;
      if (got !== 64'h1234_5678_9ABC_DEF0) begin bad++; $display("FAIL hold_load: got %h", got); end
      dbg_addr = 64'h300; #1;
      total++;
      if (dbg_data !== '0) begin bad++; $display("FAIL hold_unsampled: got %h want 0", dbg_data); end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] got;
      do_op(1, 0, 64'h08, 64'hCAFE_F00D, 0, 0, '0, got);
      do_op(0, 0, 64'h08 + DEPTH*8, 64'h0, 0, 0, '0, got);
      total++;
      if (got !== 64'hCAFE_F00D) begin bad++; $display("FAIL wrap_load: got %h want cafef00d", got); end
      do_op(0, 0, 64'h0B, 64'h0, 2, 0, '0, got);
      total++;
      if (got !== 64'hCAFE_F00D) begin bad++; $display("FAIL offset_load: got %h want cafef00d", got); end
   endtask

   task automatic test_random();
      int idxs [5] = '{0, 1, 2, 5, 255};
      logic [DW-1:0] got, a, d;
      bit w, c;
      for (int n = 0; n < 40; n++) begin
         a = (DW'(idxs[$urandom_range(0, 4)]) << 3) | DW'($urandom_range(0, 7))
             | (DW'($urandom) << 11);
         d = ($urandom_range(0, 4) == 0) ? '0 : {$urandom, $urandom};
         c = ($urandom_range(0, 2) == 0);
         w = $urandom_range(0, 1);
         do_op(w, c, a, d, $urandom_range(0, 3), 0, '0, got);
      end
   endtask

   // LATENCY=0 instance, response ready tied high, request valid held high
   // continuously: one op every two cycles, response valid the cycle after accept.
   task automatic test_back_to_back();
      logic [DW-1:0] a, d, exp;
      bit w, c;
      @(negedge clk);
      for (int n = 0; n < 16; n++) begin
         a = (DW'($urandom_range(0, 3)) << 3) | DW'($urandom_range(0, 7)) | (DW'($urandom) << 7);
         d = {$urandom, $urandom};
         w = (n % 2 == 0);
         c = !w && ($urandom_range(0, 3) == 0);
         if (c && $urandom_range(0, 1) == 1) d = '0;
         exp = zmodel_op(w, c, a, d);
         z_req_val = 1'b1; z_req_is_write = w; z_req_is_cas = c; z_req_addr = a; z_req_data = d;
         total++;
         if (z_req_rdy !== 1'b1 || z_rsp_val !== 1'b0 || z_rsp_data !== '0) begin
            bad++; $display("FAIL b2b_idle n=%0d: rdy=%b val=%b data=%h want 1 0 0", n, z_req_rdy, z_rsp_val, z_rsp_data);
         end
         @(posedge clk);
         @(negedge clk);
         total++;
         if (z_rsp_val !== 1'b1 || z_req_rdy !== 1'b0 || z_rsp_data !== exp) begin
            bad++; $display("FAIL b2b_rsp n=%0d: val=%b rdy=%b data=%h want 1 0 %h", n, z_rsp_val, z_req_rdy, z_rsp_data, exp);
         end
         z_dbg_addr = a; #1;
         total++;
         if (z_dbg_data !== zmodel[zwidx(a)]) begin
            bad++; $display("FAIL b2b_dbg n=%0d: got %h want %h", n, z_dbg_data, zmodel[zwidx(a)]);
         end
         @(posedge clk);
         @(negedge clk);
      end
      z_req_val = 1'b0;
   endtask

   task automatic test_reset_busy();
      logic [DW-1:0] got;
      @(negedge clk);
      req_val = 1'b1; req_is_write = 1'b1; req_is_cas = 1'b0;
      req_addr = 64'h10; req_data = 64'h5555_AAAA; rsp_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_val = 1'b0;
      total++;
      if (req_rdy !== 1'b0) begin bad++; $display("FAIL rstbusy_in_busy: rdy=%b want 0", req_rdy); end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clear_models();
      total++;
      if (req_rdy !== 1'b1 || rsp_val !== 1'b0 || rsp_data !== '0) begin
         bad++; $display("FAIL rstbusy_outputs: rdy=%b val=%b data=%h want 1 0 0", req_rdy, rsp_val, rsp_data);
      end
      rst = 1'b0;
      do_op(0, 0, 64'h10, 64'h0, 0, 0, '0, got);
      total++;
      if (got !== '0) begin bad++; $display("FAIL rstbusy_dropped: got %h want 0", got); end
   endtask

   initial begin
      rst = 1'b1;
      req_val = 1'b0; req_is_write = 1'b0; req_is_cas = 1'b0; req_addr = '0; req_data = '0;
      rsp_rdy = 1'b0; dbg_addr = '0;
      z_req_val = 1'b0; z_req_is_write = 1'b0; z_req_is_cas = 1'b0;
      z_req_addr = '0; z_req_data = '0; z_dbg_addr = '0;
      test_reset();
      test_store_load();
      test_cas();
      test_hold();
      test_wrap();
      test_random();
      test_back_to_back();
      test_reset_busy();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
